// File: rtl/rx_hex_display.sv
// Live hex view of the last four received UART bytes on an 8-digit multiplexed 7-segment display.
// Optional build macro RX_BLANK_EN: digits belonging to bytes not yet received are shown blank.
module rx_hex_display #(
  parameter int SCAN_CNT_MAX = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  input  logic       clear,
  output logic [7:0] led_en,
  output logic [7:0] led_seg,
  output logic [2:0] count
);

  localparam int SCAN_W = (SCAN_CNT_MAX > 2) ? $clog2(SCAN_CNT_MAX) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CNT_MAX - 1);
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] hex_font(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  function automatic logic [7:0] digit_enable(input logic [2:0] sel);
    return ~(8'b0000_0001 << sel);
  endfunction

  logic [7:0]        hist_p0 [4];
  logic [2:0]        count_p0;
  logic [SCAN_W-1:0] scan_cnt_p0;
  logic [2:0]        idx_p0;

  // Stage 0: byte history, fill count and digit scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) hist_p0[k] <= 8'h00;
      count_p0 <= 3'd0;
    end else if (clear) begin
      for (int k = 0; k < 4; k++) hist_p0[k] <= 8'h00;
      count_p0 <= 3'd0;
    end else if (valid) begin
      hist_p0[3] <= hist_p0[2];
      hist_p0[2] <= hist_p0[1];
      hist_p0[1] <= hist_p0[0];
      hist_p0[0] <= data;
      if (count_p0 != 3'd4) count_p0 <= count_p0 + 3'd1;
    end
  end

  // The scan is independent of traffic so the display never stalls on clear/valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_p0 <= '0;
      idx_p0      <= 3'd0;
    end else if (scan_cnt_p0 == SCAN_LAST) begin
      scan_cnt_p0 <= '0;
      idx_p0      <= idx_p0 + 3'd1;
    end else begin
      scan_cnt_p0 <= scan_cnt_p0 + SCAN_W'(1);
    end
  end

  assign count = count_p0;

  logic [1:0] byte_sel;
  logic [7:0] sel_byte;
  logic [3:0] sel_nib;
  logic       sel_filled;
  logic [7:0] seg_next;

  always_comb begin
    byte_sel   = idx_p0[2:1];
    sel_byte   = hist_p0[byte_sel];
    sel_nib    = idx_p0[0] ? sel_byte[7:4] : sel_byte[3:0];
    sel_filled = ({1'b0, byte_sel} < count_p0);
`ifdef RX_BLANK_EN
    seg_next   = sel_filled ? hex_font(sel_nib) : SEG_BLANK;
`else
    seg_next   = hex_font(sel_nib);
`endif
  end

  // Stage 1: registered display drive, one cycle behind idx/history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_en  <= SEG_BLANK;
      led_seg <= SEG_BLANK;
    end else begin
      led_en  <= digit_enable(idx_p0);
      led_seg <= seg_next;
    end
  end

`ifndef RX_BLANK_EN
  logic unused_fill;
  assign unused_fill = sel_filled;
`endif

endmodule
